// File: rtl/fir_mc_fifo_system_if.sv
// Sample-in and read-out streams of fir_mc_fifo_system.
// master = sample source / bus reader side, slave = the filter block.
interface fir_mc_fifo_system_if #(
  parameter int BIT_PREC = 8,
  parameter int CH_W     = 2,
  parameter int DWIDTH   = 32
);
  logic                in_valid;
  logic                in_ready;
  logic [CH_W-1:0]     in_ch;
  logic [BIT_PREC-1:0] in_sample;
  logic                rd_valid;
  logic                rd_ready;
  logic [DWIDTH-1:0]   rd_data;

  modport master (output in_valid, in_ch, in_sample, rd_ready,
                  input  in_ready, rd_valid, rd_data);
  modport slave  (input  in_valid, in_ch, in_sample, rd_ready,
                  output in_ready, rd_valid, rd_data);
endinterface

// File: rtl/fir_mc_fifo_system.sv
// Multi-channel FIR: one serial MAC shared by NUM_CH delay lines, results tagged and queued
// in a drop-oldest FIFO. Define FIR_MC_DROP_CNT_EN to build the saturating drop counter.
module fir_mc_fifo_system #(
  parameter  int BIT_PREC = 8,
  parameter  int COEF_W   = 8,
  parameter  int NUM_TAPS = 16,
  parameter  int NUM_CH   = 4,
  parameter  int DWIDTH   = 32,
  parameter  int MEM_SIZE = 1024,
  localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int TAP_W    = $clog2(NUM_TAPS),
  localparam int OUT_SIZE = BIT_PREC + COEF_W + TAP_W
)(
  input  logic                clk,
  input  logic                rst,
  input  logic                fir_en,
  input  logic                coef_we,
  input  logic [TAP_W-1:0]    coef_addr,
  input  logic [COEF_W-1:0]   coef_wdata,
  input  logic                fifo_clr,
  fir_mc_fifo_system_if.slave s,
  output logic                empty_flg,
  output logic                full_flg,
  output logic [15:0]         drop_cnt
);
  localparam int PW = BIT_PREC + COEF_W;
  localparam int AW = $clog2(MEM_SIZE);

  if (DWIDTH < OUT_SIZE + CH_W) begin : g_width_chk
    $error("DWIDTH cannot hold channel tag plus full-precision result");
  end

  typedef enum logic [1:0] {IDLE, MAC, PUSH} state_e;
  state_e state_q, state_d;

  logic signed [BIT_PREC-1:0] x_q [NUM_CH][NUM_TAPS];
  logic signed [COEF_W-1:0]   c_q [NUM_TAPS];
  logic signed [OUT_SIZE-1:0] acc_q;
  logic [TAP_W-1:0]           k_q;
  logic [CH_W-1:0]            ch_q;
  logic signed [PW-1:0]       prod;
  logic                       accept, last_tap;

  assign last_tap = (k_q == TAP_W'(NUM_TAPS - 1));
  assign prod     = PW'(x_q[ch_q][k_q]) * PW'(c_q[k_q]);

  always_comb begin
    state_d    = state_q;
    s.in_ready = 1'b0;
    accept     = 1'b0;
    unique case (state_q)
      IDLE: begin
        s.in_ready = fir_en && !rst;
        accept     = s.in_valid && fir_en && !rst;
        if (accept) state_d = MAC;
      end
      MAC:     if (last_tap) state_d = PUSH;
      PUSH:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      k_q     <= '0;
      ch_q    <= '0;
      for (int c = 0; c < NUM_CH; c++)
        for (int t = 0; t < NUM_TAPS; t++) x_q[c][t] <= '0;
      for (int t = 0; t < NUM_TAPS; t++) c_q[t] <= '0;
    end else begin
      state_q <= state_d;
      // A write coinciding with an accept lands before the first MAC cycle reads it.
      if (state_q == IDLE && coef_we) c_q[coef_addr] <= coef_wdata;
      unique case (state_q)
        IDLE: if (accept) begin
          x_q[s.in_ch][0] <= s.in_sample;
          for (int t = 1; t < NUM_TAPS; t++) x_q[s.in_ch][t] <= x_q[s.in_ch][t-1];
          ch_q  <= s.in_ch;
          acc_q <= '0;
          k_q   <= '0;
        end
        MAC: begin
          acc_q <= acc_q + OUT_SIZE'(prod);
          k_q   <= k_q + TAP_W'(1);
        end
        default: ;
      endcase
    end
  end

  logic [DWIDTH-1:0] mem [MEM_SIZE];
  logic [AW-1:0]     wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0]       cnt_q, cnt_d;
  logic [DWIDTH-1:0] word, head_q, head_d;
  logic              push, pop, full_now, drop;
  logic              rd_valid_q, empty_q, full_q;

  assign word     = {ch_q, (DWIDTH-CH_W)'(acc_q)};
  assign push     = (state_q == PUSH);
  assign pop      = s.rd_ready && (cnt_q != '0);
  assign full_now = (cnt_q == (AW+1)'(MEM_SIZE));
  assign drop     = push && full_now && !pop;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (fifo_clr) begin
      wptr_d = '0;
      rptr_d = '0;
      cnt_d  = '0;
    end else begin
      if (push)        wptr_d = wptr_q + AW'(1);
      if (pop || drop) rptr_d = rptr_q + AW'(1);
      if (push && !pop && !full_now) cnt_d = cnt_q + (AW+1)'(1);
      else if (pop && !push)         cnt_d = cnt_q - (AW+1)'(1);
    end
    // Bypass the word being written when it becomes the new head in the same edge.
    head_d = (push && (wptr_q == rptr_d)) ? word : mem[rptr_d];
    if (fifo_clr) head_d = '0;
  end

  always_ff @(posedge clk) begin
    if (!rst && push && !fifo_clr) mem[wptr_q] <= word;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      cnt_q      <= '0;
      head_q     <= '0;
      rd_valid_q <= 1'b0;
      empty_q    <= 1'b1;
      full_q     <= 1'b0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      cnt_q      <= cnt_d;
      head_q     <= head_d;
      rd_valid_q <= (cnt_d != '0);
      empty_q    <= (cnt_d == '0);
      full_q     <= (cnt_d == (AW+1)'(MEM_SIZE));
    end
  end

  assign s.rd_valid = rd_valid_q;
  assign s.rd_data  = head_q;
  assign empty_flg  = empty_q;
  assign full_flg   = full_q;

`ifdef FIR_MC_DROP_CNT_EN
  logic [15:0] drop_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                       drop_q <= '0;
    else if (fifo_clr)             drop_q <= '0;
    else if (drop && drop_q != '1) drop_q <= drop_q + 16'd1;
  end
  assign drop_cnt = drop_q;
`else
  assign drop_cnt = '0;
`endif
endmodule

// File: tb/tb_fir_mc_fifo_system.sv
// Directed bench for fir_mc_fifo_system: 4 taps, 2 channels, 4-deep FIFO, 32-bit words.
// Expected words are {ch, sign-extended result} computed by hand.
module tb_fir_mc_fifo_system;
  logic        clk = 1'b0;
  logic        rst, fir_en, coef_we, fifo_clr;
  logic [1:0]  coef_addr;
  logic [7:0]  coef_wdata;
  logic        empty_flg, full_flg;
  logic [15:0] drop_cnt;
  int          checks = 0;
  int          fails  = 0;

`ifdef FIR_MC_DROP_CNT_EN
  localparam logic [15:0] EXP_DROP = 16'd2;
`else
  localparam logic [15:0] EXP_DROP = 16'd0;
`endif

  fir_mc_fifo_system_if #(.BIT_PREC(8), .CH_W(1), .DWIDTH(32)) bus ();

  fir_mc_fifo_system #(
    .BIT_PREC(8), .COEF_W(8), .NUM_TAPS(4), .NUM_CH(2), .DWIDTH(32), .MEM_SIZE(4)
  ) dut (
    .clk(clk), .rst(rst), .fir_en(fir_en), .coef_we(coef_we), .coef_addr(coef_addr),
    .coef_wdata(coef_wdata), .fifo_clr(fifo_clr), .s(bus), .empty_flg(empty_flg),
    .full_flg(full_flg), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic send(input logic ch, input logic [7:0] smp, input logic we,
                      input logic [1:0] a, input logic [7:0] d);
    int n = 0;
    @(negedge clk);
    bus.in_valid = 1'b1; bus.in_ch = ch; bus.in_sample = smp;
    coef_we = we; coef_addr = a; coef_wdata = d;
    while (!bus.in_ready && n < 50) begin @(negedge clk); n++; end
    checks++;
    if (!bus.in_ready) begin
      fails++;
      $display("FAIL send_accept: in_ready=%0b after %0d cycles, required 1", bus.in_ready, n);
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0; coef_we = 1'b0;
  endtask

  task automatic write_coef(input logic [1:0] a, input logic [7:0] d);
    @(negedge clk);
    coef_we = 1'b1; coef_addr = a; coef_wdata = d;
    @(negedge clk);
    coef_we = 1'b0;
  endtask

  task automatic pop(output logic [31:0] d);
    int n = 0;
    @(negedge clk);
    while (!bus.rd_valid && n < 30) begin @(negedge clk); n++; end
    checks++;
    if (!bus.rd_valid) begin
      fails++;
      $display("FAIL pop_wait: rd_valid=%0b after %0d cycles, required 1", bus.rd_valid, n);
      d = 'x;
    end else begin
      d = bus.rd_data;
      bus.rd_ready = 1'b1;
      @(negedge clk);
      bus.rd_ready = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; fir_en = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (bus.in_ready !== 1'b0) begin fails++; $display("FAIL rst_in_ready: got %0b, required 0", bus.in_ready); end
    checks++; if (bus.rd_valid !== 1'b0) begin fails++; $display("FAIL rst_rd_valid: got %0b, required 0", bus.rd_valid); end
    checks++; if (empty_flg !== 1'b1) begin fails++; $display("FAIL rst_empty: got %0b, required 1", empty_flg); end
    checks++; if (full_flg !== 1'b0) begin fails++; $display("FAIL rst_full: got %0b, required 0", full_flg); end
    checks++; if (bus.rd_data !== 32'h0) begin fails++; $display("FAIL rst_rd_data: got %h, required 0", bus.rd_data); end
    checks++; if (drop_cnt !== 16'h0) begin fails++; $display("FAIL rst_drop_cnt: got %0d, required 0", drop_cnt); end
    rst = 1'b0;
    @(negedge clk);
    checks++; if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL post_rst_in_ready: got %0b, required 1", bus.in_ready); end
  endtask

  task automatic test_impulse();
    logic [7:0]  smp [5] = '{8'd1, 8'd0, 8'd0, 8'd0, 8'd0};
    logic [31:0] exp [5] = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd0};
    logic [31:0] d;
    int lat;
    write_coef(2'd0, 8'd1); write_coef(2'd1, 8'd2);
    write_coef(2'd2, 8'd3); write_coef(2'd3, 8'd4);
    for (int i = 0; i < 5; i++) begin
      send(1'b0, smp[i], 1'b0, 2'd0, 8'd0);
      lat = 0;
      do begin @(negedge clk); lat++; end while (!bus.rd_valid && lat < 20);
      checks++; if (lat != 6) begin fails++; $display("FAIL impulse_latency[%0d]: got %0d cycles, required 6", i, lat); end
      pop(d);
      checks++; if (d !== exp[i]) begin fails++; $display("FAIL impulse_data[%0d]: got %h, required %h", i, d, exp[i]); end
    end
  endtask

  task automatic test_channel_isolation();
    logic        ch  [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [7:0]  smp [6] = '{8'd10, 8'hFB, 8'd10, 8'hFB, 8'd10, 8'hFB};
    logic [31:0] exp [6] = '{32'h0000_000A, 32'hFFFF_FFFB, 32'h0000_0014,
                             32'hFFFF_FFF6, 32'h0000_001E, 32'hFFFF_FFF1};
    logic [31:0] d;
    for (int t = 0; t < 4; t++) write_coef(2'(t), 8'd1);
    for (int i = 0; i < 6; i++) begin
      send(ch[i], smp[i], 1'b0, 2'd0, 8'd0);
      pop(d);
      checks++; if (d !== exp[i]) begin fails++; $display("FAIL chan_iso[%0d]: got %h, required %h", i, d, exp[i]); end
      if (i == 1) begin
        checks++;
        if (d[30:18] !== 13'h1FFF) begin fails++; $display("FAIL chan_sign_ext: got %h, required 1fff", d[30:18]); end
      end
    end
  endtask

  task automatic test_overflow();
    logic [31:0] d;
    write_coef(2'd0, 8'd1); write_coef(2'd1, 8'd0);
    write_coef(2'd2, 8'd0); write_coef(2'd3, 8'd0);
    for (int i = 1; i <= 6; i++) send(1'b0, 8'(i), 1'b0, 2'd0, 8'd0);
    repeat (8) @(negedge clk);
    checks++; if (full_flg !== 1'b1) begin fails++; $display("FAIL ovf_full: got %0b, required 1", full_flg); end
    checks++; if (drop_cnt !== EXP_DROP) begin fails++; $display("FAIL ovf_drop_cnt: got %0d, required %0d", drop_cnt, EXP_DROP); end
    for (int i = 3; i <= 6; i++) begin
      pop(d);
      checks++; if (d !== 32'(i)) begin fails++; $display("FAIL ovf_read[%0d]: got %h, required %h", i, d, 32'(i)); end
    end
    checks++; if (empty_flg !== 1'b1) begin fails++; $display("FAIL ovf_empty: got %0b, required 1", empty_flg); end
    checks++; if (bus.rd_valid !== 1'b0) begin fails++; $display("FAIL ovf_rd_valid: got %0b, required 0", bus.rd_valid); end
  endtask

  task automatic test_full_push_pop();
    logic [31:0] d;
    @(negedge clk); fifo_clr = 1'b1;
    @(negedge clk); fifo_clr = 1'b0;
    checks++; if (drop_cnt !== 16'd0) begin fails++; $display("FAIL clr_drop_cnt: got %0d, required 0", drop_cnt); end
    for (int i = 11; i <= 14; i++) send(1'b0, 8'(i), 1'b0, 2'd0, 8'd0);
    repeat (8) @(negedge clk);
    checks++; if (full_flg !== 1'b1) begin fails++; $display("FAIL fpp_full_before: got %0b, required 1", full_flg); end
    send(1'b0, 8'd15, 1'b0, 2'd0, 8'd0);
    repeat (5) @(negedge clk);
    d = bus.rd_data;
    bus.rd_ready = 1'b1;
    @(negedge clk);
    bus.rd_ready = 1'b0;
    checks++; if (d !== 32'd11) begin fails++; $display("FAIL fpp_head: got %h, required %h", d, 32'd11); end
    checks++; if (drop_cnt !== 16'd0) begin fails++; $display("FAIL fpp_drop_cnt: got %0d, required 0", drop_cnt); end
    checks++; if (full_flg !== 1'b1) begin fails++; $display("FAIL fpp_full_after: got %0b, required 1", full_flg); end
    for (int i = 12; i <= 15; i++) begin
      pop(d);
      checks++; if (d !== 32'(i)) begin fails++; $display("FAIL fpp_read[%0d]: got %h, required %h", i, d, 32'(i)); end
    end
  endtask

  task automatic test_coef_gating();
    logic [31:0] d;
    send(1'b1, 8'd3, 1'b0, 2'd0, 8'd0);
    repeat (2) @(negedge clk);
    coef_we = 1'b1; coef_addr = 2'd0; coef_wdata = 8'd7;
    @(negedge clk);
    coef_we = 1'b0;
    pop(d);
    checks++; if (d !== 32'h8000_0003) begin fails++; $display("FAIL gate_cur: got %h, required 80000003", d); end
    send(1'b1, 8'd4, 1'b0, 2'd0, 8'd0);
    pop(d);
    checks++; if (d !== 32'h8000_0004) begin fails++; $display("FAIL gate_next: got %h, required 80000004", d); end
    send(1'b1, 8'd5, 1'b1, 2'd0, 8'd2);
    pop(d);
    checks++; if (d !== 32'h8000_000A) begin fails++; $display("FAIL write_first: got %h, required 8000000a", d); end
  endtask

  task automatic test_reset_mid_mac();
    logic [31:0] d;
    send(1'b0, 8'd9, 1'b0, 2'd0, 8'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    checks++; if (bus.rd_valid !== 1'b0) begin fails++; $display("FAIL mid_rst_rd_valid: got %0b, required 0", bus.rd_valid); end
    checks++; if (empty_flg !== 1'b1) begin fails++; $display("FAIL mid_rst_empty: got %0b, required 1", empty_flg); end
    checks++; if (full_flg !== 1'b0) begin fails++; $display("FAIL mid_rst_full: got %0b, required 0", full_flg); end
    send(1'b0, 8'd1, 1'b0, 2'd0, 8'd0);
    pop(d);
    checks++; if (d !== 32'h0) begin fails++; $display("FAIL mid_rst_impulse: got %h, required 0", d); end
  endtask

  initial begin
    rst = 1'b1; fir_en = 1'b1; coef_we = 1'b0; coef_addr = '0; coef_wdata = '0; fifo_clr = 1'b0;
    bus.in_valid = 1'b0; bus.in_ch = '0; bus.in_sample = '0; bus.rd_ready = 1'b0;
    test_reset();
    test_impulse();
    test_channel_isolation();
    test_overflow();
    test_full_push_pop();
    test_coef_gating();
    test_reset_mid_mac();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
